// File: rtl/fft_reorder_buf_if.sv
// Stream bundle for fft_reorder_buf: input beat stream with in_ready backpressure,
// reordered output beat stream with ready_out backpressure.
// frame_err exists only when FRAME_ERR_EN is defined.
interface fft_reorder_buf_if #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned NUM   = 16
);
    logic signed [WIDTH-1:0] din_re  [0:NUM-1];
    logic signed [WIDTH-1:0] din_im  [0:NUM-1];
    logic                    valid_in;
    logic                    in_ready;
    logic signed [WIDTH-1:0] dout_re [0:NUM-1];
    logic signed [WIDTH-1:0] dout_im [0:NUM-1];
    logic                    valid_out;
    logic                    ready_out;
`ifdef FRAME_ERR_EN
    logic                    frame_err;
`endif

    // Environment side: produces input beats, consumes output beats.
    modport master (
`ifdef FRAME_ERR_EN
        input  frame_err,
`endif
        output din_re, din_im, valid_in, ready_out,
        input  in_ready, dout_re, dout_im, valid_out
    );

    // Reorder buffer side.
    modport slave (
`ifdef FRAME_ERR_EN
        output frame_err,
`endif
        input  din_re, din_im, valid_in, ready_out,
        output in_ready, dout_re, dout_im, valid_out
    );
endinterface

// File: rtl/fft_reorder_buf.sv
// FFT output reorder buffer.
// Collects a frame of DATA complex samples (COUNT beats of NUM lanes) into one bank of a
// ping-pong buffer and replays it in natural frequency order: output beat b, lane l carries
// stored sample bitrev(b*NUM + l) over log2(DATA) bits. Data passes through unmodified.
// Optional macro FRAME_ERR_EN: a valid_in gap inside a frame aborts it and pulses frame_err;
// without it, gaps simply pause the frame.
module fft_reorder_buf #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned NUM   = 16,
    parameter int unsigned DATA  = 512
) (
    input logic              clk,
    input logic              rstn,
    fft_reorder_buf_if.slave bus
);
    localparam int unsigned COUNT   = DATA / NUM;
    localparam int unsigned LogData = $clog2(DATA);
    localparam int unsigned CntW    = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(COUNT - 1);

    typedef enum logic [0:0] {StIdle, StStream} state_e;
    typedef logic signed [WIDTH-1:0] sample_t;

    // Two banks of flat sample storage, indexed by natural input sample number.
    sample_t mem_re [0:1][0:DATA-1];
    sample_t mem_im [0:1][0:DATA-1];

    state_e          state_q, state_d;
    logic            wsel_q, wsel_d;
    logic            rsel_q, rsel_d;
    logic [CntW-1:0] wcnt_q, wcnt_d;
    logic [CntW-1:0] rcnt_q, rcnt_d;
    logic [1:0]      full_q, full_d;
    sample_t         dout_re_q [0:NUM-1];
    sample_t         dout_im_q [0:NUM-1];
    sample_t         rd_re     [0:NUM-1];
    sample_t         rd_im     [0:NUM-1];
    logic            accept;
    logic            load;
`ifdef FRAME_ERR_EN
    logic            frame_err_q, frame_err_d;
`endif

    // Sample number of lane `lane` within beat `cnt`.
    function automatic logic [LogData-1:0] sidx(input logic [CntW-1:0] cnt,
                                                input int unsigned lane);
        return LogData'(int'(cnt) * NUM + lane);
    endfunction

    function automatic logic [LogData-1:0] bitrev(input logic [LogData-1:0] v);
        logic [LogData-1:0] r;
        for (int unsigned i = 0; i < LogData; i++) begin
            r[i] = v[LogData-1-i];
        end
        return r;
    endfunction

    // Bank write: one full beat per accepted input cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int unsigned l = 0; l < NUM; l++) begin
                mem_re[wsel_q][sidx(wcnt_q, l)] <= bus.din_re[l];
                mem_im[wsel_q][sidx(wcnt_q, l)] <= bus.din_im[l];
            end
        end
    end

    // Bit-reversed gather of the next output beat from the read bank.
    always_comb begin
        for (int unsigned l = 0; l < NUM; l++) begin
            rd_re[l] = mem_re[rsel_q][bitrev(sidx(rcnt_q, l))];
            rd_im[l] = mem_im[rsel_q][bitrev(sidx(rcnt_q, l))];
        end
    end

    // State register: FSM, bank pointers, counters, full flags and output beat register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            wsel_q  <= 1'b0;
            rsel_q  <= 1'b0;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            full_q  <= 2'b00;
            for (int unsigned l = 0; l < NUM; l++) begin
                dout_re_q[l] <= '0;
                dout_im_q[l] <= '0;
            end
`ifdef FRAME_ERR_EN
            frame_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            wsel_q  <= wsel_d;
            rsel_q  <= rsel_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            full_q  <= full_d;
            if (load) begin
                dout_re_q <= rd_re;
                dout_im_q <= rd_im;
            end
`ifdef FRAME_ERR_EN
            frame_err_q <= frame_err_d;
`endif
        end
    end

    // Next-state: writer bookkeeping, reader fetch and FSM transitions.
    always_comb begin
        state_d = state_q;
        wsel_d  = wsel_q;
        rsel_d  = rsel_q;
        wcnt_d  = wcnt_q;
        rcnt_d  = rcnt_q;
        full_d  = full_q;
`ifdef FRAME_ERR_EN
        frame_err_d = 1'b0;
`endif

        // Writer: a beat is taken only while the current write bank is free.
        accept = bus.valid_in && !full_q[wsel_q];
        if (accept) begin
            if (wcnt_q == LastCnt) begin
                full_d[wsel_q] = 1'b1;
                wsel_d         = ~wsel_q;
                wcnt_d         = '0;
            end else begin
                wcnt_d = wcnt_q + CntW'(1);
            end
        end
`ifdef FRAME_ERR_EN
        else if (!bus.valid_in && (wcnt_q != '0)) begin
            // Gap inside a frame: drop the partial frame, restart at beat 0.
            wcnt_d      = '0;
            frame_err_d = 1'b1;
        end
`endif

        // Reader: the output register takes a new beat when empty or being handed off.
        // rcnt is the next beat to fetch. The bank is released as soon as its last beat
        // sits in the output register, so the writer can refill it with no bubble.
        load = full_q[rsel_q] && ((state_q == StIdle) || bus.ready_out);
        if (load) begin
            if (rcnt_q == LastCnt) begin
                full_d[rsel_q] = 1'b0;
                rsel_d         = ~rsel_q;
                rcnt_d         = '0;
            end else begin
                rcnt_d = rcnt_q + CntW'(1);
            end
        end

        unique case (state_q)
            StIdle: begin
                if (full_q[rsel_q]) begin
                    state_d = StStream;
                end
            end
            StStream: begin
                // Handshake with nothing left to fetch empties the output register.
                if (bus.ready_out && !full_q[rsel_q]) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: all taken from registers.
    always_comb begin
        bus.in_ready  = ~full_q[wsel_q];
        bus.valid_out = (state_q == StStream);
        bus.dout_re   = dout_re_q;
        bus.dout_im   = dout_im_q;
`ifdef FRAME_ERR_EN
        bus.frame_err = frame_err_q;
`endif
    end
endmodule
